bcd2_7seg_scan: RTL and testbench
=================================

// Module: bcd2_7seg_scan
// PURPOSE
//   Downstream display stage for the two-digit BCD seconds counter.
//   Captures the tens and units BCD digits on a load strobe and drives one
//   multiplexed common-anode 7-segment display pair.
//   Alternates between the two digits, with a guard (blank) interval at the
//   start of each slot to suppress ghosting.
//   Invalid BCD (>9) is shown as a dash.
// PARAMETERS
//   SCAN_DIV          50000  clock cycles per digit slot; SCAN_DIV >= 2
//   GUARD             16     blank cycles at start of each slot; 0 <= GUARD < SCAN_DIV
//   SEG_ACTIVE_LOW    1      1: seg pins low = segment lit
//   DIGIT_ACTIVE_LOW  1      1: an pins low = digit enabled
// PORTS
//   clk      in   1  system clock; sole clock
//   rs_n     in   1  asynchronous active-low reset
//   load     in   1  1-cycle strobe; capture bcd_lo/bcd_hi into shadow regs
//   bcd_lo   in   4  units digit (from counter units output)
//   bcd_hi   in   4  tens digit (from counter tens output)
//   seg      out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   an       out  2  an[0] = units digit, an[1] = tens digit; polarity per DIGIT_ACTIVE_LOW
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low.
//   - Reset (rs_n=0, takes effect immediately, including mid-slot):
//     - shadow_lo = shadow_hi = 0; cnt = 0; slot = LO.
//     - seg = all segments unlit; an = both digits disabled.
//   - Slot FSM, two states, LO -> HI -> LO:
//     - cnt runs 0..SCAN_DIV-1.
//     - At cnt == SCAN_DIV-1: cnt wraps to 0 and slot toggles.
//   - an: the current slot's digit is enabled exactly while cnt >= GUARD; otherwise both disabled.
//   - an is registered and aligned to cnt, with no extra cycle of lag.
//   - Frame period = 2*SCAN_DIV cycles.
//   - seg is decoded from the slot's shadow digit at the slot-start edge and held for the whole slot.
//   - seg never changes mid-slot.
//   - load: shadow regs update on the edge where load=1.
//     - New values are displayed from the next slot start.
//     - If load coincides with a slot boundary, the starting slot uses the pre-edge shadow value.
//     - The new value appears one slot later.
//     - load held high recaptures every cycle; no error.
//   - Decode (active-high, before polarity):
//     - 0=3F, 1=06, 2=5B, 3=4F, 4=66
//     - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
//     - A..F = 40 (dash, segment g only)
//   - Output polarity: seg = decode ^ {7{SEG_ACTIVE_LOW}}.
//   - Digit enable polarity is applied likewise via DIGIT_ACTIVE_LOW.
//   - No other states. Unreachable slot encodings recover to LO on the next edge.
// CONFIGURATION
//   - LEAD_ZERO_BLANK_EN defined:
//     - When shadow_hi == 0, seg is all unlit for the whole HI slot.
//     - an timing is unchanged.
//   - LEAD_ZERO_BLANK_EN undefined: tens digit 0 is displayed as "0" (3F).
//   - Both builds: the units digit is never blanked.
// TESTING (SCAN_DIV=8, GUARD=2, both polarity params = 1 unless noted)
//   1. rs_n=0 for 3 cycles -> seg=7'h7F, an=2'b11; release -> LO slot.
//      an=2'b11 for cnt 0..1, an=2'b10 for cnt 2..7.
//   2. load with bcd_hi=4, bcd_lo=7, then run 2 frames:
//      - LO slot: seg=7'h78, an=2'b10 (cnt 2..7).
//      - HI slot: seg=7'h19, an=2'b01 (cnt 2..7).
//      - Period 16 cycles.
//   3. load bcd_lo=3 at LO-slot cnt=4 -> seg stays old value until the next LO slot start, then 7'h30.
//      load coincident with a boundary -> takes effect one slot later.
//   4. bcd_lo=4'hC loaded -> LO slot seg=7'h3F (dash).
//      Same case with SEG_ACTIVE_LOW=0 -> seg=7'h40.
//   5. bcd_hi=0:
//      - With LEAD_ZERO_BLANK_EN: HI slot seg=7'h7F and an still pulses 2'b01.
//      - Without LEAD_ZERO_BLANK_EN: HI slot seg=7'h40.
//   6. rs_n asserted at HI-slot cnt=5 -> seg=7'h7F and an=2'b11 immediately, before the next clk edge.
//      Shadow digits read 0 after release.

Source files
------------

// File: rtl/bcd2_7seg_scan.sv
// Two-digit BCD display scanner for a multiplexed common-anode 7-seg pair.
// Optional LEAD_ZERO_BLANK_EN: blanks the tens digit while it holds zero.
module bcd2_7seg_scan #(
  parameter int SCAN_DIV         = 50000,
  parameter int GUARD            = 16,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rs_n,
  input  logic       load,
  input  logic [3:0] bcd_lo,
  input  logic [3:0] bcd_hi,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_POL = (DIGIT_ACTIVE_LOW != 0);

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } slot_t;

  slot_t         slot, slot_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    shadow_lo, shadow_hi;
  logic [6:0]    seg_nx, lit_nx;
  logic [1:0]    an_nx, en_nx;
  logic [3:0]    digit_nx;
  logic          wrap;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'h3F;
      4'd1:    r = 7'h06;
      4'd2:    r = 7'h5B;
      4'd3:    r = 7'h4F;
      4'd4:    r = 7'h66;
      4'd5:    r = 7'h6D;
      4'd6:    r = 7'h7D;
      4'd7:    r = 7'h07;
      4'd8:    r = 7'h7F;
      4'd9:    r = 7'h6F;
      default: r = 7'h40;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      slot      <= LO;
      cnt       <= '0;
      shadow_lo <= 4'd0;
      shadow_hi <= 4'd0;
      seg       <= {7{SEG_POL}};
      an        <= {2{DIG_POL}};
    end else begin
      slot <= slot_nx;
      cnt  <= cnt_nx;
      seg  <= seg_nx;
      an   <= an_nx;
      if (load) begin
        shadow_lo <= bcd_lo;
        shadow_hi <= bcd_hi;
      end
    end
  end

  always_comb begin
    wrap    = (cnt >= LAST);
    slot_nx = slot;
    cnt_nx  = cnt + CW'(1);
    if (wrap) cnt_nx = '0;
    case (slot)
      LO:      if (wrap) slot_nx = HI;
      HI:      if (wrap) slot_nx = LO;
      default: slot_nx = LO;
    endcase

    // an is computed from the next count so it lines up with cnt
    en_nx = 2'b00;
    if (cnt_nx >= GUARD_C) en_nx = (slot_nx == HI) ? 2'b10 : 2'b01;
    an_nx = en_nx ^ {2{DIG_POL}};

    digit_nx = (slot_nx == HI) ? shadow_hi : shadow_lo;
    lit_nx   = decode(digit_nx);
`ifdef LEAD_ZERO_BLANK_EN
    if (slot_nx == HI && shadow_hi == 4'd0) lit_nx = 7'h00;
`endif

    // segments change only on the slot-start edge
    seg_nx = seg;
    if (wrap) seg_nx = lit_nx ^ {7{SEG_POL}};
  end

endmodule

// File: tb/tb_bcd2_7seg_scan.sv
// Bench for bcd2_7seg_scan: vector table, corner sequences, random vs model.
// Two instances: active-low pins (defaults) and active-high pins.
module tb_bcd2_7seg_scan;

  localparam int D = 8;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rs_n;
  logic       load;
  logic [3:0] bcd_lo, bcd_hi;
  logic [6:0] seg, seg_p;
  logic [1:0] an, an_p;

  always #5 clk = ~clk;

  bcd2_7seg_scan #(.SCAN_DIV(D), .GUARD(G),
    .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)) u_dut (
    .clk(clk), .rs_n(rs_n), .load(load),
    .bcd_lo(bcd_lo), .bcd_hi(bcd_hi),
    .seg(seg), .an(an)
  );

  bcd2_7seg_scan #(.SCAN_DIV(D), .GUARD(G),
    .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(0)) u_dut_p (
    .clk(clk), .rs_n(rs_n), .load(load),
    .bcd_lo(bcd_lo), .bcd_hi(bcd_hi),
    .seg(seg_p), .an(an_p)
  );

  int tests = 0;
  int fails = 0;

  // reference model: k = edges since reset release
  int         k;
  int         m_lo, m_hi;
  logic [6:0] m_disp;
  bit         m_valid;
  logic [6:0] dec_tab [0:15];

  typedef struct {
    logic [3:0] hi;
    logic [3:0] lo;
    logic [6:0] exp_lo;
    logic [6:0] exp_hi;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [6:0] lit_of(input int digit, input bit is_hi);
`ifdef LEAD_ZERO_BLANK_EN
    if (is_hi && digit == 0) return 7'h00;
`endif
    return dec_tab[digit];
  endfunction

  task automatic chk(input string name, input logic [6:0] act,
                     input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic check_all();
    int         c, s;
    logic [1:0] en;
    logic [6:0] lit;
    c   = k % D;
    s   = (k / D) % 2;
    en  = (c >= G) ? ((s == 1) ? 2'b10 : 2'b01) : 2'b00;
    lit = m_valid ? m_disp : 7'h00;
    chk("seg", seg, lit ^ 7'h7F);
    chk("an", {5'd0, an}, {5'd0, ~en});
    chk("seg_p", seg_p, lit);
    chk("an_p", {5'd0, an_p}, {5'd0, en});
  endtask

  task automatic step();
    int s;
    @(posedge clk);
    k++;
    if (k % D == 0) begin
      s       = (k / D) % 2;
      m_disp  = lit_of((s == 1) ? m_hi : m_lo, s == 1);
      m_valid = 1'b1;
    end
    if (load) begin
      m_lo = int'(bcd_lo);
      m_hi = int'(bcd_hi);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic pulse_load(input logic [3:0] hi, input logic [3:0] lo);
    bcd_hi = hi;
    bcd_lo = lo;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  // advance at least one cycle, then up to the given slot/count
  task automatic run_to(input int s, input int c);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!((k % D) == c && ((k / D) % 2) == s) && n < 2 * D + 1);
    tests++;
    if (!((k % D) == c && ((k / D) % 2) == s)) begin
      fails++;
      $display("FAIL run_to: got k=%0d wanted slot %0d cnt %0d", k, s, c);
    end
  endtask

  task automatic do_reset(input int n);
    rs_n = 1'b0;
    load = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", {5'd0, an}, 7'h03);
    chk("rst_seg_p", seg_p, 7'h00);
    chk("rst_an_p", {5'd0, an_p}, 7'h00);
    k       = 0;
    m_lo    = 0;
    m_hi    = 0;
    m_valid = 1'b0;
    rs_n    = 1'b1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rs_n   = 1'b0;
    load   = 1'b0;
    bcd_lo = 4'd0;
    bcd_hi = 4'd0;
    dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    vecs[0] = '{4'd4, 4'd7, 7'h78, 7'h19};
`ifdef LEAD_ZERO_BLANK_EN
    vecs[1] = '{4'd0, 4'd3, 7'h30, 7'h7F};
`else
    vecs[1] = '{4'd0, 4'd3, 7'h30, 7'h40};
`endif
    vecs[2] = '{4'd9, 4'hC, 7'h3F, 7'h10};
    vecs[3] = '{4'hF, 4'd8, 7'h00, 7'h3F};
    vecs[4] = '{4'd1, 4'd5, 7'h12, 7'h79};
    vecs[5] = '{4'd2, 4'd6, 7'h02, 7'h24};

    do_reset(3);
    repeat (2 * D) step();

    foreach (vecs[i]) begin
      pulse_load(vecs[i].hi, vecs[i].lo);
      run_to(1, 0);
      run_to(0, 4);
      chk("tab_lo", seg, vecs[i].exp_lo);
      chk("tab_lo_p", seg_p, vecs[i].exp_lo ^ 7'h7F);
      run_to(1, 4);
      chk("tab_hi", seg, vecs[i].exp_hi);
      chk("tab_hi_p", seg_p, vecs[i].exp_hi ^ 7'h7F);
    end

    // mid-slot load: old digit held until next LO start
    pulse_load(4'd4, 4'd7);
    run_to(1, 0);
    run_to(0, 4);
    pulse_load(4'd4, 4'd3);
    run_to(0, 7);
    chk("mid_hold", seg, 7'h78);
    run_to(1, 0);
    chk("mid_hi", seg, 7'h19);
    run_to(0, 0);
    chk("mid_new", seg, 7'h30);

    // load on the LO->HI boundary edge: starting HI slot still old
    run_to(0, 7);
    pulse_load(4'd2, 4'd3);
    chk("bnd_old", seg, 7'h19);
    run_to(1, 0);
    chk("bnd_new", seg, 7'h24);

    // async reset mid HI slot
    run_to(1, 5);
    #1 rs_n = 1'b0;
    #1;
    chk("arst_seg", seg, 7'h7F);
    chk("arst_an", {5'd0, an}, 7'h03);
    chk("arst_seg_p", seg_p, 7'h00);
    do_reset(2);
    run_to(0, 3);
    chk("post_rst_lo", seg, 7'h7F);
    run_to(0, 3);
    chk("shadow_lo0", seg, 7'h40);
    run_to(1, 3);
`ifdef LEAD_ZERO_BLANK_EN
    chk("shadow_hi0", seg, 7'h7F);
`else
    chk("shadow_hi0", seg, 7'h40);
`endif
    chk("hi0_an", {5'd0, an}, 7'h01);

    // random traffic, including held load and ignored input changes
    for (int i = 0; i < 600; i++) begin
      bcd_lo = 4'($urandom_range(0, 15));
      bcd_hi = 4'($urandom_range(0, 15));
      load   = ($urandom_range(0, 3) == 0);
      if (i >= 200 && i < 230) load = 1'b1;
      if (i == 400) do_reset(2);
      step();
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
